press_event_arbiter: RTL and testbench
======================================

# press_event_arbiter

Collects push-button presses from N raw inputs and hands them one at a time to a single shared consumer, such as the display/counter update logic. Each channel has its own press qualifier: an input must be high for two consecutive samples, and it yields exactly one event per press. Qualified events are latched as pending and granted round-robin over a valid/ready handshake. A channel that is pressed again before its previous event is consumed raises a sticky overflow flag.

## Interface
- `N`, default 4: number of button channels; legal range 2..8.
- `IDW`, default 2: width of `evt_id`; must equal ceil(log2(N)).

Ports:
- `clk` input, 1 bit: system clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset; asserting it low clears all state immediately.
- `btn` input, N bits: raw button levels, already synchronous to `clk`.
- `evt_ready` input, 1 bit: consumer accepts the offered event this cycle.
- `clr_ovf` input, 1 bit: single-cycle pulse that clears all overflow flags.
- `evt_valid` output, 1 bit: an event is offered.
- `evt_id` output, IDW bits: channel index of the offered event.
- `pending` output, N bits: per-channel pending event flags.
- `ovf` output, N bits: per-channel sticky overflow flags.

## Operation
Per-channel qualifier: a 3-state FSM, one instance per `btn[i]`.
- IDLE: `btn[i]`=0 → IDLE; `btn[i]`=1 → ARM.
- ARM: `btn[i]`=0 → IDLE; `btn[i]`=1 → HELD and raise `det[i]` for that edge.
- HELD: `btn[i]`=1 → HELD; `btn[i]`=0 → IDLE.
- A 1-cycle high glitch (IDLE→ARM→IDLE) produces no event.
- Holding the button produces exactly one event.
- A new event needs a return to IDLE and then two consecutive high samples.

Pending register, per channel at each edge:
- `det[i]`=1 → `pending[i]`=1. Set wins, even if the same edge grants channel i.
- Else, if a handshake grants channel i → `pending[i]`=0.
- Else `pending[i]` holds.

Overflow register, per channel:
- `ovf[i]` is set when `det[i]`=1, `pending[i]`=1, and channel i is not being granted on that edge.
- `clr_ovf`=1 clears all bits, except that a set on the same edge wins for that bit.

Arbiter:
- Round-robin pointer `ptr` (IDW bits) resets to 0.
- `evt_valid` = OR of `pending`; it is combinational from registers only.
- `evt_id` = the first index i with `pending[i]`=1, scanning ptr, ptr+1, …, N-1, 0, …, ptr-1 with modulo-N wrap.
- When `evt_valid`=0, `evt_id` = 0.
- A handshake occurs on a rising edge with `evt_valid`=1 and `evt_ready`=1:
  - `pending[evt_id]` clears, unless `det` sets it again on that edge.
  - `ptr` ← (`evt_id`+1) mod N, so the index after N-1 is 0.
- `evt_ready` with `evt_valid`=0 has no effect.
- `evt_id` and `evt_valid` are stable while `evt_ready`=0 unless a new `det` adds a higher-priority pending bit. The consumer samples only on the handshake edge.

## Timing
- Reset state: all FSMs IDLE, `pending`=0, `ovf`=0, `ptr`=0, `evt_valid`=0, `evt_id`=0.
- Reset is asynchronous. A mid-operation reset discards every pending event and overflow immediately.
- Detection latency: `btn[i]` is first sampled high at edge k. `pending[i]`=1 after edge k+1, and `evt_valid` rises in the same cycle.
- Grant latency: zero added cycles. With `evt_ready` tied high, one event retires per cycle.
- Back-to-back handshakes across channels are allowed every cycle.
- Only one event is granted per cycle. With K channels pending and `evt_ready` held high, all are drained in K cycles.

## Test plan
- Single press, `evt_ready`=1:
  - Stimulus: `btn`=0001 held for 5 cycles.
  - Response: `evt_valid` high for exactly 1 cycle, 2 edges after the rise, with `evt_id`=0. Afterwards `pending`=0000 and `ovf`=0000.
- Glitch rejection:
  - Stimulus: `btn[2]` high for 1 cycle only.
  - Response: `pending` stays 0000 and `evt_valid` never rises.
- Round-robin fairness:
  - Stimulus: `pending` set to 1111 simultaneously, `evt_ready`=1.
  - Response: grants in the order 0, 1, 2, 3.
  - Follow-up: channels 0 and 3 pressed again simultaneously with `ptr`=1. Response: grants 3 then 0 (wrap-around).
- Overflow:
  - Stimulus: `evt_ready`=0; press channel 1, release, then press again.
  - Response: `ovf`=0010 and `pending`=0010.
  - Follow-up: a `clr_ovf` pulse. Response: `ovf`=0000.
- Simultaneous grant and re-detect:
  - Stimulus: channel 1's second `det` lands on the same edge as its handshake.
  - Response: `pending[1]` stays 1 and `ovf[1]` stays 0. Channel 1 is re-offered once any other pending channels have been granted.
- Reset mid-operation:
  - Stimulus: `pending`=0110, `ovf`=0100, `ptr`=2; drive `reset` low between clock edges.
  - Response: all outputs go to 0 immediately, without waiting for a clock edge. After release, the first grant scans from index 0.

Source files
------------

// File: rtl/press_event_arbiter.sv
// press_event_arbiter
//   Qualifies raw push-button levels (two consecutive high samples, one event
//   per press), latches each qualified event as pending, and offers pending
//   events one at a time to a single consumer, round-robin, over valid/ready.
//   A channel pressed again while its previous event is still pending raises
//   a sticky overflow flag.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-low reset
//   btn        : N raw button levels, synchronous to clk
//   evt_ready  : consumer accepts the offered event this cycle
//   clr_ovf    : single-cycle pulse clearing all overflow flags
//   evt_valid  : an event is offered
//   evt_id     : channel index of the offered event (0 when none)
//   pending    : per-channel pending event flags
//   ovf        : per-channel sticky overflow flags
module press_event_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   btn,
  input  logic           evt_ready,
  input  logic           clr_ovf,
  output logic           evt_valid,
  output logic [IDW-1:0] evt_id,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   ovf
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_HELD = 2'd2;

  logic [1:0]     r_state [N];
  logic [N-1:0]   r_pending;
  logic [N-1:0]   r_ovf;
  logic [IDW-1:0] r_ptr;

  logic [N-1:0]   w_det;
  logic [N-1:0]   w_gnt;
  logic           w_valid;
  logic           w_found;
  logic [IDW-1:0] w_id;
  logic [IDW:0]   w_sum;
  logic           w_hs;

  // ---- Stage: per-channel press qualifier ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) r_state[i] <= S_IDLE;
    end else begin
      for (int i = 0; i < N; i++) begin
        case (r_state[i])
          S_IDLE:  r_state[i] <= btn[i] ? S_ARM  : S_IDLE;
          S_ARM:   r_state[i] <= btn[i] ? S_HELD : S_IDLE;
          S_HELD:  r_state[i] <= btn[i] ? S_HELD : S_IDLE;
          default: r_state[i] <= S_IDLE;
        endcase
      end
    end
  end

  // The event fires on the edge that moves ARM -> HELD, so a one-sample
  // glitch never reaches the pending register.
  always_comb begin
    w_det = '0;
    for (int i = 0; i < N; i++) begin
      w_det[i] = (r_state[i] == S_ARM) && btn[i];
    end
  end

  // ---- Stage: round-robin selection (registers only) ----
  // Scan ptr, ptr+1, ... with modulo-N wrap; w_sum is one bit wider than
  // the index so ptr+k never overflows before the wrap subtraction.
  always_comb begin
    w_found = 1'b0;
    w_id    = '0;
    w_sum   = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(N)) w_sum = w_sum - (IDW+1)'(N);
      if (!w_found && r_pending[w_sum[IDW-1:0]]) begin
        w_found = 1'b1;
        w_id    = w_sum[IDW-1:0];
      end
    end
  end

  assign w_valid = |r_pending;
  assign w_hs    = w_valid && evt_ready;
  assign w_gnt   = w_hs ? (N'(1) << w_id) : '0;

  // ---- Stage: pending / overflow / pointer update ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= '0;
      r_ovf     <= '0;
      r_ptr     <= '0;
    end else begin
      // A new detection wins over a grant on the same edge.
      r_pending <= w_det | (r_pending & ~w_gnt);
      // Overflow only when the earlier event is not leaving on this edge;
      // a set on the clear edge still wins.
      r_ovf     <= (clr_ovf ? '0 : r_ovf) | (w_det & r_pending & ~w_gnt);
      if (w_hs) begin
        r_ptr <= (w_id == IDW'(N-1)) ? '0 : w_id + IDW'(1);
      end
    end
  end

  assign evt_valid = w_valid;
  assign evt_id    = w_id;
  assign pending   = r_pending;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_press_event_arbiter.sv
module tb_press_event_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   btn;
  logic           evt_ready;
  logic           clr_ovf;
  logic           evt_valid;
  logic [IDW-1:0] evt_id;
  logic [N-1:0]   pending;
  logic [N-1:0]   ovf;

  int n_tests = 0;
  int n_fail  = 0;

  press_event_arbiter #(.N(N), .IDW(IDW)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn       (btn),
    .evt_ready (evt_ready),
    .clr_ovf   (clr_ovf),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .pending   (pending),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    btn = '0; evt_ready = 1'b0; clr_ovf = 1'b0;
    reset = 1'b0;
    #2;
    n_tests++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", evt_valid); end
    n_tests++; if (evt_id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d expected 0", evt_id); end
    n_tests++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL reset_pending: got %b expected 0000", pending); end
    n_tests++; if (ovf !== 4'b0000) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0000", ovf); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_press;
    int cnt = 0;
    int first = -1;
    logic [IDW-1:0] id_first = '1;
    evt_ready = 1'b1;
    btn = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (evt_valid) begin
        if (first < 0) begin first = c; id_first = evt_id; end
        cnt++;
      end
      if (c == 4) btn = 4'b0000;
    end
    n_tests++; if (cnt != 1) begin n_fail++; $display("FAIL single_valid_cycles: got %0d expected 1", cnt); end
    n_tests++; if (first != 1) begin n_fail++; $display("FAIL single_latency: got %0d expected 1", first); end
    n_tests++; if (id_first !== 2'd0) begin n_fail++; $display("FAIL single_id: got %0d expected 0", id_first); end
    n_tests++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL single_pending: got %b expected 0000", pending); end
    n_tests++; if (ovf !== 4'b0000) begin n_fail++; $display("FAIL single_ovf: got %b expected 0000", ovf); end
  endtask

  task automatic test_glitch;
    int seen = 0;
    evt_ready = 1'b1;
    btn = 4'b0100;
    tick();
    btn = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (evt_valid) seen++;
      if (pending !== 4'b0000) seen++;
    end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL glitch_event: got %0d cycles with activity expected 0", seen); end
    n_tests++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL glitch_pending: got %b expected 0000", pending); end
  endtask

  task automatic test_round_robin;
    do_reset();
    evt_ready = 1'b1;
    btn = 4'b1111;
    tick();
    tick();
    n_tests++; if (pending !== 4'b1111) begin n_fail++; $display("FAIL rr_pending_all: got %b expected 1111", pending); end
    for (int g = 0; g < 4; g++) begin
      n_tests++;
      if (evt_valid !== 1'b1 || evt_id !== IDW'(g)) begin
        n_fail++; $display("FAIL rr_order_%0d: got valid=%b id=%0d expected valid=1 id=%0d", g, evt_valid, evt_id, g);
      end
      tick();
    end
    n_tests++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drained: got %b expected 0", evt_valid); end
    // Move the pointer to 1 by granting channel 0 alone.
    btn = 4'b0000; tick();
    btn = 4'b0001; tick(); tick(); tick();
    btn = 4'b0000; tick();
    // Channels 0 and 3 together with ptr=1: 3 first, then wrap to 0.
    btn = 4'b1001; tick(); tick();
    n_tests++; if (pending !== 4'b1001) begin n_fail++; $display("FAIL rr_wrap_pending: got %b expected 1001", pending); end
    n_tests++; if (evt_id !== 2'd3) begin n_fail++; $display("FAIL rr_wrap_first: got %0d expected 3", evt_id); end
    tick();
    n_tests++; if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin n_fail++; $display("FAIL rr_wrap_second: got valid=%b id=%0d expected valid=1 id=0", evt_valid, evt_id); end
    tick();
    n_tests++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL rr_wrap_drained: got %b expected 0", evt_valid); end
    btn = 4'b0000; tick();
  endtask

  task automatic test_overflow;
    evt_ready = 1'b0;
    btn = 4'b0010; tick(); tick();
    btn = 4'b0000; tick();
    n_tests++; if (ovf !== 4'b0000) begin n_fail++; $display("FAIL ovf_first_press: got %b expected 0000", ovf); end
    btn = 4'b0010; tick(); tick();
    n_tests++; if (ovf !== 4'b0010) begin n_fail++; $display("FAIL ovf_set: got %b expected 0010", ovf); end
    n_tests++; if (pending !== 4'b0010) begin n_fail++; $display("FAIL ovf_pending: got %b expected 0010", pending); end
    tick(); tick();
    n_tests++; if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin n_fail++; $display("FAIL ovf_stable_offer: got valid=%b id=%0d expected valid=1 id=1", evt_valid, evt_id); end
    clr_ovf = 1'b1; tick();
    clr_ovf = 1'b0;
    n_tests++; if (ovf !== 4'b0000) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0000", ovf); end
    n_tests++; if (pending !== 4'b0010) begin n_fail++; $display("FAIL ovf_clear_keeps_pending: got %b expected 0010", pending); end
    // Drain; ptr becomes 2.
    evt_ready = 1'b1; tick();
    evt_ready = 1'b0;
    btn = 4'b0000; tick();
    n_tests++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL ovf_drain: got %b expected 0000", pending); end
  endtask

  task automatic test_grant_redetect;
    // ptr is 2 here, so channel 1 is offered while it is the only one pending.
    evt_ready = 1'b0;
    btn = 4'b0010; tick(); tick();
    btn = 4'b0000; tick();
    btn = 4'b1010; tick();
    evt_ready = 1'b1;
    tick();
    // Grant of channel 1 and its re-detect on the same edge; ch3 detected too.
    n_tests++; if (pending !== 4'b1010) begin n_fail++; $display("FAIL redet_pending: got %b expected 1010", pending); end
    n_tests++; if (ovf !== 4'b0000) begin n_fail++; $display("FAIL redet_ovf: got %b expected 0000", ovf); end
    n_tests++; if (evt_id !== 2'd3) begin n_fail++; $display("FAIL redet_other_first: got %0d expected 3", evt_id); end
    tick();
    n_tests++; if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin n_fail++; $display("FAIL redet_reoffer: got valid=%b id=%0d expected valid=1 id=1", evt_valid, evt_id); end
    tick();
    n_tests++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL redet_drained: got %b expected 0", evt_valid); end
    btn = 4'b0000; evt_ready = 1'b0; tick();
  endtask

  task automatic test_reset_mid;
    do_reset();
    // Grant channel 1 to put ptr at 2.
    evt_ready = 1'b1;
    btn = 4'b0010; tick(); tick(); tick();
    btn = 4'b0000; evt_ready = 1'b0; tick();
    btn = 4'b0110; tick(); tick();
    btn = 4'b0000; tick();
    btn = 4'b0100; tick(); tick();
    btn = 4'b0000; tick();
    n_tests++; if (pending !== 4'b0110 || ovf !== 4'b0100) begin n_fail++; $display("FAIL rstmid_setup: got pending=%b ovf=%b expected 0110/0100", pending, ovf); end
    n_tests++; if (evt_id !== 2'd2) begin n_fail++; $display("FAIL rstmid_ptr_offer: got %0d expected 2", evt_id); end
    #2;
    reset = 1'b0;
    #1;
    n_tests++; if (evt_valid !== 1'b0 || evt_id !== 2'd0) begin n_fail++; $display("FAIL rstmid_async_offer: got valid=%b id=%0d expected 0/0", evt_valid, evt_id); end
    n_tests++; if (pending !== 4'b0000 || ovf !== 4'b0000) begin n_fail++; $display("FAIL rstmid_async_state: got pending=%b ovf=%b expected 0000/0000", pending, ovf); end
    #1;
    reset = 1'b1;
    btn = 4'b1010; tick(); tick();
    n_tests++; if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin n_fail++; $display("FAIL rstmid_scan_from_0: got valid=%b id=%0d expected valid=1 id=1", evt_valid, evt_id); end
    btn = 4'b0000;
  endtask

  initial begin
    btn = '0; evt_ready = 1'b0; clr_ovf = 1'b0; reset = 1'b1;
    test_reset();
    test_single_press();
    test_glitch();
    test_round_robin();
    test_overflow();
    test_grant_redetect();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
